// File: rtl/sdram_responder_pkg.sv
// Shared widths, command decoding and constants for the SDRAM-style slave responder.
package sdram_responder_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 2;

  localparam logic PROTO_ERR_CODE = 1'b1;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_READ,
    CMD_WRITE,
    CMD_PROTO
  } cmd_e;

  // Simultaneous read and write strobes decode to CMD_PROTO, which behaves as a write.
  function automatic cmd_e decode_cmd(input logic chipselect, input logic read_n,
                                      input logic write_n);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (chipselect) begin
      if (!read_n && !write_n) cmd = CMD_PROTO;
      else if (!write_n)       cmd = CMD_WRITE;
      else if (!read_n)        cmd = CMD_READ;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_responder_rd_pipe.sv
// Fixed-latency read return delay line; data stages only load behind a valid so the
// output word holds its last returned value.
module sdram_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] valid;
  logic [WIDTH-1:0]   data [LATENCY];

  always_ff @(posedge clk) begin
    if (flush) begin
      valid <= '0;
      for (int i = 0; i < LATENCY; i++) data[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      if (in_valid) data[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid[i] <= valid[i-1];
        if (valid[i-1]) data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = valid[LATENCY-1];
  assign out_data  = data[LATENCY-1];

endmodule

// File: rtl/sdram_responder.sv
// Avalon-style SDRAM slave model: byte-lane backing array, fixed-latency in-order reads,
// optional periodic wait-state injection and a sticky protocol-error flag.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int STALL_EVERY  = 0,
  parameter int STALL_LEN    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     read_n,
  input  logic                     write_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic [BE_W-1:0]          byteenable,
  input  logic signed [DATA_W-1:0] writedata,
  output logic                     waitrequest,
  output logic signed [DATA_W-1:0] readdata,
  output logic                     readdatavalid,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_PENDING + 1);

  cmd_e              cmd;
  logic              stall_active;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic [DATA_W-1:0] rd_word;
  logic [PW-1:0]     pending;
  logic [AW-1:0]     idx;
  logic              unused_addr_bits;

  logic [7:0] mem_lo [DEPTH];
  logic [7:0] mem_hi [DEPTH];

  if (STALL_EVERY > 0) begin : g_stall
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
      if (reset)                                  stall_cnt <= '0;
      else if (stall_cnt == 32'(STALL_EVERY - 1)) stall_cnt <= '0;
      else                                        stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_active = (stall_cnt < 32'(STALL_LEN));
  end else begin : g_no_stall
    assign stall_active = 1'b0;
  end

  // waitrequest must never depend on the request inputs, only on state and reset.
  assign waitrequest = reset || stall_active || (pending == PW'(MAX_PENDING));

  assign cmd       = decode_cmd(chipselect, read_n, write_n);
  assign accept    = (cmd != CMD_NONE) && !waitrequest;
  assign wr_accept = accept && ((cmd == CMD_WRITE) || (cmd == CMD_PROTO));
  assign rd_accept = accept && (cmd == CMD_READ);

  assign idx              = address[AW-1:0];
  assign unused_addr_bits = ^address[ADDR_W-1:AW];
  assign rd_word          = {mem_hi[idx], mem_lo[idx]};

  always_ff @(posedge clk) begin
    if (wr_accept && byteenable[0]) mem_lo[idx] <= writedata[7:0];
    if (wr_accept && byteenable[1]) mem_hi[idx] <= writedata[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
      pending   <= '0;
    end else begin
      if (rd_accept) rd_count <= rd_count + 32'd1;
      if (wr_accept) wr_count <= wr_count + 32'd1;
      if (accept && (cmd == CMD_PROTO)) proto_err <= PROTO_ERR_CODE;
      if (rd_accept && !pipe_valid)      pending <= pending + PW'(1);
      else if (!rd_accept && pipe_valid) pending <= pending - PW'(1);
    end
  end

  sdram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // Gating with reset hides a return that is due in the very cycle reset rises.
  assign readdatavalid = pipe_valid && !reset;
  assign readdata      = reset ? '0 : $signed(pipe_data);

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench: default responder, a wait-state streaming instance and a long-latency
// instance that exercises the in-flight read limit.
module tb_sdram_responder;

  logic clk;
  logic reset;

  logic        m_cs, m_rn, m_wn;
  logic [31:0] m_addr;
  logic [1:0]  m_be;
  logic [15:0] m_wd;
  logic        m_wait, m_rdv, m_perr;
  logic [15:0] m_rdata;
  logic [31:0] m_rdc, m_wrc;

  logic        s_cs, s_rn, s_wn;
  logic [31:0] s_addr;
  logic [1:0]  s_be;
  logic [15:0] s_wd;
  logic        s_wait, s_rdv, s_perr;
  logic [15:0] s_rdata;
  logic [31:0] s_rdc, s_wrc;

  logic        l_cs, l_rn, l_wn;
  logic [31:0] l_addr;
  logic [1:0]  l_be;
  logic [15:0] l_wd;
  logic        l_wait, l_rdv, l_perr;
  logic [15:0] lat_rdata_unused;
  logic [31:0] l_rdc, l_wrc;

  int checks     = 0;
  int failures   = 0;
  int s_pulses   = 0;
  int s_pend_max = 0;

  localparam int STREAM_N = 784;

  bit lat_wait_exp [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  bit lat_rdv_exp  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  sdram_responder u_dut (
    .clk(clk), .reset(reset), .chipselect(m_cs), .read_n(m_rn), .write_n(m_wn),
    .address(m_addr), .byteenable(m_be), .writedata(m_wd), .waitrequest(m_wait),
    .readdata(m_rdata), .readdatavalid(m_rdv), .rd_count(m_rdc), .wr_count(m_wrc),
    .proto_err(m_perr)
  );

  sdram_responder #(.STALL_EVERY(8), .STALL_LEN(2)) u_stall (
    .clk(clk), .reset(reset), .chipselect(s_cs), .read_n(s_rn), .write_n(s_wn),
    .address(s_addr), .byteenable(s_be), .writedata(s_wd), .waitrequest(s_wait),
    .readdata(s_rdata), .readdatavalid(s_rdv), .rd_count(s_rdc), .wr_count(s_wrc),
    .proto_err(s_perr)
  );

  sdram_responder #(.READ_LATENCY(5), .MAX_PENDING(2)) u_lat (
    .clk(clk), .reset(reset), .chipselect(l_cs), .read_n(l_rn), .write_n(l_wn),
    .address(l_addr), .byteenable(l_be), .writedata(l_wd), .waitrequest(l_wait),
    .readdata(lat_rdata_unused), .readdatavalid(l_rdv), .rd_count(l_rdc), .wr_count(l_wrc),
    .proto_err(l_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 97 + 256);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    m_cs = 1'b0; m_rn = 1'b1; m_wn = 1'b1; m_addr = '0; m_be = '0; m_wd = '0;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one command on the default instance for exactly one clock edge.
  task automatic applyStimulus(input logic cs, input logic rn, input logic wn,
                               input logic [31:0] a, input logic [1:0] be,
                               input logic [15:0] wd);
    m_cs = cs; m_rn = rn; m_wn = wn; m_addr = a; m_be = be; m_wd = wd;
    waitCycle();
  endtask

  task automatic expectRead(input string tag, input logic [31:0] a, input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, 1'b1, a, 2'b00, 16'h0000);
    setIdle();
    #1;
    checkOutput({tag, "_early"}, m_rdv, 1'b0);
    waitCycle();
    checkOutput({tag, "_rdv"}, m_rdv, 1'b1);
    checkOutput({tag, "_data"}, m_rdata, exp);
  endtask

  always @(negedge clk) begin
    if (s_rdv) begin
      checkOutput("stall_data", s_rdata, pat(s_pulses));
      s_pulses++;
    end
    if (int'(u_stall.pending) > s_pend_max) s_pend_max = int'(u_stall.pending);
  end

  task automatic mainSeq();
    #1;
    checkOutput("rel_wait", m_wait, 1'b0);
    checkOutput("rel_rdc", m_rdc, 0);
    checkOutput("rel_wrc", m_wrc, 0);
    checkOutput("rel_perr", m_perr, 1'b0);
    checkOutput("rel_rdata", m_rdata, 16'h0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 2'b11, 16'h1234);
    expectRead("wr_rd", 32'd5, 16'h1234);
    waitCycle();
    checkOutput("hold_rdv", m_rdv, 1'b0);
    checkOutput("hold_data", m_rdata, 16'h1234);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 2'b01, 16'hABCD);
    expectRead("partial", 32'd5, 16'h12CD);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 2'b00, 16'hFFFF);
    setIdle();
    #1;
    checkOutput("be00_wrc", m_wrc, 3);
    expectRead("be00", 32'd5, 16'h12CD);
    expectRead("alias", 32'h8000_0405, 16'h12CD);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd9, 2'b11, 16'h5A5A);
    setIdle();
    #1;
    checkOutput("proto_flag", m_perr, 1'b1);
    checkOutput("proto_wrc", m_wrc, 4);
    checkOutput("proto_rdc", m_rdc, 4);
    for (int i = 0; i < 3; i++) begin
      checkOutput("proto_no_rdv", m_rdv, 1'b0);
      waitCycle();
    end
    expectRead("proto_data", 32'd9, 16'h5A5A);
    checkOutput("proto_sticky", m_perr, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'd5, 2'b00, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 2'b11, 16'h0000);
    setIdle();
    #1;
    checkOutput("cs0_rdc", m_rdc, 5);
    checkOutput("cs0_wrc", m_wrc, 4);
    checkOutput("cs0_no_rdv", m_rdv, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 2'b00, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd9, 2'b00, 16'h0000);
    #1;
    checkOutput("b2b_rdv0", m_rdv, 1'b1);
    checkOutput("b2b_data0", m_rdata, 16'h12CD);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 2'b00, 16'h0000);
    setIdle();
    #1;
    checkOutput("b2b_rdv1", m_rdv, 1'b1);
    checkOutput("b2b_data1", m_rdata, 16'h5A5A);
    waitCycle();
    checkOutput("b2b_rdv2", m_rdv, 1'b1);
    checkOutput("b2b_data2", m_rdata, 16'h12CD);
    waitCycle();
    checkOutput("b2b_end", m_rdv, 1'b0);
    checkOutput("b2b_rdc", m_rdc, 8);
  endtask

  task automatic latSeq();
    for (int k = 0; k < 9; k++) begin
      #1;
      checkOutput($sformatf("lat_wait_k%0d", k), l_wait, lat_wait_exp[k]);
      checkOutput($sformatf("lat_rdv_k%0d", k), l_rdv, lat_rdv_exp[k]);
      waitCycle();
    end
    l_cs = 1'b0; l_rn = 1'b1;
  endtask

  task automatic streamAccept(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = !s_wait;
      waitCycle();
    end
  endtask

  task automatic streamSeq();
    logic ok;
    int   budget;
    for (int k = 0; k < 9; k++) begin
      #1;
      checkOutput($sformatf("stall_wait_k%0d", k), s_wait, ((k % 8) < 2));
      waitCycle();
    end
    for (int i = 0; i < STREAM_N; i++) begin
      s_cs = 1'b1; s_rn = 1'b1; s_wn = 1'b0; s_be = 2'b11;
      s_addr = 32'(400000 + i); s_wd = pat(i);
      streamAccept(ok);
      if (!ok) begin
        checkOutput("stall_wr_timeout", 1'b0, 1'b1);
        break;
      end
    end
    for (int i = 0; i < STREAM_N; i++) begin
      s_cs = 1'b1; s_rn = 1'b0; s_wn = 1'b1; s_be = 2'b00;
      s_addr = 32'(400000 + i); s_wd = '0;
      streamAccept(ok);
      if (!ok) begin
        checkOutput("stall_rd_timeout", 1'b0, 1'b1);
        break;
      end
    end
    s_cs = 1'b0; s_rn = 1'b1; s_wn = 1'b1;
    budget = 0;
    while (s_pulses < STREAM_N && budget < 50) begin
      waitCycle();
      budget++;
    end
    checkOutput("stall_pulses", s_pulses, STREAM_N);
    checkOutput("stall_rdc", s_rdc, STREAM_N);
    checkOutput("stall_wrc", s_wrc, STREAM_N);
    checkOutput("stall_pend_le_max", (s_pend_max <= 4), 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    setIdle();
    s_cs = 1'b0; s_rn = 1'b1; s_wn = 1'b1; s_addr = '0; s_be = '0; s_wd = '0;
    l_cs = 1'b0; l_rn = 1'b1; l_wn = 1'b1; l_addr = 32'd3; l_be = '0; l_wd = '0;

    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("rst_wait", m_wait, 1'b1);
      checkOutput("rst_rdv", m_rdv, 1'b0);
      checkOutput("rst_stall_wait", s_wait, 1'b1);
    end
    checkOutput("rst_rdc", m_rdc, 0);

    reset = 1'b0;
    l_cs = 1'b1; l_rn = 1'b0;
    fork
      mainSeq();
      streamSeq();
      latSeq();
    join

    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 2'b00, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd9, 2'b00, 16'h0000);
    setIdle();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rdv", m_rdv, 1'b0);
    checkOutput("mid_rst_wait", m_wait, 1'b1);
    waitCycle();
    reset = 1'b0;
    #1;
    checkOutput("mid_pending", u_dut.pending, 0);
    checkOutput("mid_rdc", m_rdc, 0);
    checkOutput("mid_perr", m_perr, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mid_no_rdv", m_rdv, 1'b0);
      waitCycle();
    end
    expectRead("mem_kept", 32'd5, 16'h12CD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
